// File: rtl/imm_gen_pipe_pkg.sv
// ---------------------------------------------------------------------------
// imm_pkg -- shared definitions for the pipelined immediate generator.
//   imm_fmt_e   : 3-bit immediate format code (I,S,B,U,J,Z, reserved, none)
//   OP_*        : RV32/RV64 major opcodes that carry an immediate
//   imm_decode  : instruction word -> immediate format (auto-decode mode)
// ---------------------------------------------------------------------------
package imm_pkg;

    typedef enum logic [2:0] {
        IMM_I    = 3'b000,
        IMM_S    = 3'b001,
        IMM_B    = 3'b010,
        IMM_U    = 3'b011,
        IMM_J    = 3'b100,
        IMM_Z    = 3'b101,
        IMM_RSV  = 3'b110,
        IMM_NONE = 3'b111
    } imm_fmt_e;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // SYSTEM splits on funct3[2]: the CSR*I forms carry a 5-bit zimm in the
    // rs1 field, everything else (ecall/ebreak/CSR register forms) is I-type.
    function automatic imm_fmt_e imm_decode(input logic [31:0] inst);
        imm_fmt_e fmt;
        case (inst[6:0])
            OP_IMM, OP_LOAD, OP_JALR, OP_IMM32: fmt = IMM_I;
            OP_STORE:                           fmt = IMM_S;
            OP_BRANCH:                          fmt = IMM_B;
            OP_LUI, OP_AUIPC:                   fmt = IMM_U;
            OP_JAL:                             fmt = IMM_J;
            OP_SYSTEM:                          fmt = inst[14] ? IMM_Z : IMM_I;
            default:                            fmt = IMM_NONE;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// ---------------------------------------------------------------------------
// imm_gen_pipe_if -- instruction-in / immediate-out stream bundle.
//   in_valid/in_ready/inst/ext_op : upstream (decode) side
//   flush                         : discard everything buffered or incoming
//   out_valid/out_ready/imm/imm_fmt/no_imm : downstream (execute) side
//   master : the environment driving instructions and consuming immediates
//   slave  : the immediate generator
// ---------------------------------------------------------------------------
interface imm_gen_pipe_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     inst;
    logic [2:0]      ext_op;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] imm;
    logic [2:0]      imm_fmt;
    logic            no_imm;

    modport master (
        output in_valid, inst, ext_op, flush, out_ready,
        input  in_ready, out_valid, imm, imm_fmt, no_imm
    );

    modport slave (
        input  in_valid, inst, ext_op, flush, out_ready,
        output in_ready, out_valid, imm, imm_fmt, no_imm
    );
endinterface

// File: rtl/imm_gen_pipe_extract.sv
// ---------------------------------------------------------------------------
// imm_extract -- combinational immediate assembly.
//   inst_hi : instruction bits [31:7] (numbered as in the full word)
//   fmt     : immediate format to apply
//   imm     : XLEN-wide immediate, sign-extended from inst[31] (Z: zero-ext)
//   no_imm  : format carries no immediate; imm is 0
// ---------------------------------------------------------------------------
module imm_extract
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     inst_hi,
    input  imm_fmt_e        fmt,
    output logic [XLEN-1:0] imm,
    output logic            no_imm
);

    // 32-bit image of the immediate with the sign already in bit 31.
    logic [31:0] raw;

    always_comb begin
        // NOTE: every output of a combinational block gets a default before
        // the case, so no path leaves a value unassigned (no latch).
        raw    = '0;
        no_imm = 1'b0;
        case (fmt)
            IMM_I: raw = {{20{inst_hi[31]}}, inst_hi[31:20]};
            IMM_S: raw = {{20{inst_hi[31]}}, inst_hi[31:25], inst_hi[11:7]};
            IMM_B: raw = {{19{inst_hi[31]}}, inst_hi[31], inst_hi[7],
                          inst_hi[30:25], inst_hi[11:8], 1'b0};
            IMM_U: raw = {inst_hi[31:12], 12'b0};
            IMM_J: raw = {{11{inst_hi[31]}}, inst_hi[31], inst_hi[19:12],
                          inst_hi[20], inst_hi[30:21], 1'b0};
            IMM_Z: raw = {27'b0, inst_hi[19:15]};
            default: no_imm = 1'b1;
        endcase
        // raw[31] is 0 for Z and for "no immediate", so one signed widening
        // covers every format.
        imm = XLEN'($signed(raw));
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// imm_gen_pipe -- pipelined immediate generator with a 2-entry skid buffer.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : imm_gen_pipe_if.slave (instruction in, immediate out, flush)
// Parameters:
//   XLEN        : 32 or 64, width of the generated immediate
//   AUTO_DECODE : 1 = format from the opcode, 0 = format from bus.ext_op
// The immediate is computed at the input and registered, so outputs come
// straight from the main register one cycle after acceptance.
// ---------------------------------------------------------------------------
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter bit AUTO_DECODE = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    imm_gen_pipe_if.slave bus
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    typedef struct packed {
        logic [XLEN-1:0] imm;
        imm_fmt_e        fmt;
        logic            no_imm;
    } entry_t;

    imm_fmt_e        in_fmt;
    logic [XLEN-1:0] in_imm;
    logic            in_no_imm;
    entry_t          in_entry;
    entry_t          main_q;
    entry_t          skid_q;
    logic            main_valid;
    logic            skid_valid;

    always_comb begin
        in_fmt   = AUTO_DECODE ? imm_decode(bus.inst) : imm_fmt_e'(bus.ext_op);
        in_entry = '{imm: in_imm, fmt: in_fmt, no_imm: in_no_imm};
    end

    imm_extract #(
        .XLEN (XLEN)
    ) u_extract (
        .inst_hi (bus.inst[31:7]),
        .fmt     (in_fmt),
        .imm     (in_imm),
        .no_imm  (in_no_imm)
    );

    // Occupancy: skid_valid implies main_valid. While skid is empty the
    // block is ready, so every in_valid is an accept.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples values from before this edge.
        if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
        end else if (bus.flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (skid_valid) begin
            // Full: no accept this cycle; a pop promotes the older skid entry.
            if (bus.out_ready) begin
                main_q     <= skid_q;
                skid_valid <= 1'b0;
            end
        end else if (!main_valid || bus.out_ready) begin
            // Main free or draining: new entry goes straight to main
            // (pass-through on simultaneous pop and accept).
            main_valid <= bus.in_valid;
            if (bus.in_valid) begin
                main_q <= in_entry;
            end
        end else if (bus.in_valid) begin
            // Main stalled: park the accepted entry in skid.
            skid_valid <= 1'b1;
        end
    end

    // NOTE: the skid payload has no reset; it is only ever read while
    // skid_valid is set, and it tracks the input whenever the skid is empty.
    always_ff @(posedge clk) begin
        if (!skid_valid) begin
            skid_q <= in_entry;
        end
    end

    // in_ready is the inverse of a flop, so it changes only on clock edges.
    // out_valid is masked during reset so nothing transfers while rst is high.
    assign bus.in_ready  = ~skid_valid;
    assign bus.out_valid = main_valid & ~rst;
    assign bus.imm       = main_q.imm;
    assign bus.imm_fmt   = main_q.fmt;
    assign bus.no_imm    = main_q.no_imm;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// tb_imm_gen_pipe -- bench for imm_gen_pipe. Three instances run in lockstep
// on a shared stimulus stream: XLEN=32 auto-decode, XLEN=64 auto-decode and
// XLEN=32 with explicit ext_op. A FIFO reference model (capacity 2) predicts
// handshakes; immediates are derived from the encoding rules arithmetically.
// ---------------------------------------------------------------------------
module tb_imm_gen_pipe;
    import imm_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] inst;
    logic [2:0]  ext_op;
    logic        flush;
    logic        out_ready;

    int total = 0;
    int bad   = 0;

    imm_gen_pipe_if #(.XLEN(32)) if_a32 ();
    imm_gen_pipe_if #(.XLEN(64)) if_a64 ();
    imm_gen_pipe_if #(.XLEN(32)) if_m32 ();

    assign if_a32.in_valid = in_valid;  assign if_a32.inst = inst;  assign if_a32.ext_op = ext_op;
    assign if_a32.flush = flush;        assign if_a32.out_ready = out_ready;
    assign if_a64.in_valid = in_valid;  assign if_a64.inst = inst;  assign if_a64.ext_op = ext_op;
    assign if_a64.flush = flush;        assign if_a64.out_ready = out_ready;
    assign if_m32.in_valid = in_valid;  assign if_m32.inst = inst;  assign if_m32.ext_op = ext_op;
    assign if_m32.flush = flush;        assign if_m32.out_ready = out_ready;

    imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(1'b1)) u_a32 (.clk(clk), .rst(rst), .bus(if_a32.slave));
    imm_gen_pipe #(.XLEN(64), .AUTO_DECODE(1'b1)) u_a64 (.clk(clk), .rst(rst), .bus(if_a64.slave));
    imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(1'b0)) u_m32 (.clk(clk), .rst(rst), .bus(if_m32.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] inst;
        logic [2:0]  ext;
    } item_t;

    item_t q[$];
    bit    after_reset;

    function automatic longint sx(input longint v, input int bits);
        longint half = longint'(1) << (bits - 1);
        return (v >= half) ? v - (half << 1) : v;
    endfunction

    function automatic void ref_out(input logic [31:0] in, input logic [2:0] ext, input bit auto_dec,
                                    output logic [63:0] e_imm, output logic [2:0] e_fmt, output logic e_no);
        logic [2:0] f;
        longint     v;
        if (!auto_dec) f = ext;
        else begin
            case (in[6:0])
                7'b0010011, 7'b0000011, 7'b1100111, 7'b0011011: f = 3'd0;
                7'b0100011:             f = 3'd1;
                7'b1100011:             f = 3'd2;
                7'b0110111, 7'b0010111: f = 3'd3;
                7'b1101111:             f = 3'd4;
                7'b1110011:             f = in[14] ? 3'd5 : 3'd0;
                default:                f = 3'd7;
            endcase
        end
        e_no = 1'b0;
        case (f)
            3'd0: v = sx(longint'(in[31:20]), 12);
            3'd1: v = sx(longint'(in[31:25]) * 32 + longint'(in[11:7]), 12);
            3'd2: v = sx(longint'(in[31]) * 4096 + longint'(in[7]) * 2048
                         + longint'(in[30:25]) * 32 + longint'(in[11:8]) * 2, 13);
            3'd3: v = sx(longint'(in[31:12]) * 4096, 32);
            3'd4: v = sx(longint'(in[31]) * 1048576 + longint'(in[19:12]) * 4096
                         + longint'(in[20]) * 2048 + longint'(in[30:21]) * 2, 21);
            3'd5: v = longint'(in[19:15]);
            default: begin
                v    = 0;
                e_no = 1'b1;
            end
        endcase
        e_imm = 64'(v);
        e_fmt = f;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic cmp(input string tag, input bit is64, input bit auto_dec, input logic ov,
                       input logic ir, input logic [63:0] imm, input logic [2:0] fmt, input logic no);
        logic [63:0] e_imm;
        logic [2:0]  e_fmt;
        logic        e_no;
        bit          ev;
        ev = !rst && (q.size() > 0);
        check({tag, ".out_valid"}, 64'(ov), 64'(ev));
        check({tag, ".in_ready"}, 64'(ir), 64'(q.size() < 2));
        if (ev) begin
            ref_out(q[0].inst, q[0].ext, auto_dec, e_imm, e_fmt, e_no);
            if (!is64) e_imm = {32'b0, e_imm[31:0]};
            check({tag, ".imm"}, imm, e_imm);
            check({tag, ".imm_fmt"}, 64'(fmt), 64'(e_fmt));
            check({tag, ".no_imm"}, 64'(no), 64'(e_no));
        end else if (after_reset) begin
            check({tag, ".rst_imm"}, imm, 64'd0);
            check({tag, ".rst_fmt"}, 64'(fmt), 64'd0);
            check({tag, ".rst_no_imm"}, 64'(no), 64'd0);
        end
    endtask

    task automatic model_check();
        cmp("a32", 1'b0, 1'b1, if_a32.out_valid, if_a32.in_ready, 64'(if_a32.imm), if_a32.imm_fmt, if_a32.no_imm);
        cmp("a64", 1'b1, 1'b1, if_a64.out_valid, if_a64.in_ready, if_a64.imm, if_a64.imm_fmt, if_a64.no_imm);
        cmp("m32", 1'b0, 1'b0, if_m32.out_valid, if_m32.in_ready, 64'(if_m32.imm), if_m32.imm_fmt, if_m32.no_imm);
    endtask

    task automatic model_update();
        bit ev;
        bit er;
        after_reset = rst;
        if (rst || flush) q.delete();
        else begin
            ev = q.size() > 0;
            er = q.size() < 2;
            if (ev && out_ready) void'(q.pop_front());
            if (in_valid && er) q.push_back('{inst: inst, ext: ext_op});
        end
    endtask

    // One clock: model comparison on the falling edge, model step on the
    // rising edge, return 1 time unit after it (outputs settled).
    task automatic tick();
        @(negedge clk);
        model_check();
        @(posedge clk);
        model_update();
        #1;
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [31:0] inst;
        logic [2:0]  ext;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        no;
        logic [2:0]  fmt_m;
        logic        no_m;
    } vec_t;

    vec_t vt[12];

    task automatic run_table();
        vt[0]  = '{32'hFFF00093, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 1'b0, 3'd0, 1'b0};
        vt[1]  = '{32'hFE112E23, 3'd1, 64'hFFFF_FFFF_FFFF_FFFC, 3'd1, 1'b0, 3'd1, 1'b0};
        vt[2]  = '{32'hFE000CE3, 3'd2, 64'hFFFF_FFFF_FFFF_FFF8, 3'd2, 1'b0, 3'd2, 1'b0};
        vt[3]  = '{32'h123450B7, 3'd3, 64'h0000_0000_1234_5000, 3'd3, 1'b0, 3'd3, 1'b0};
        vt[4]  = '{32'hFFDFF06F, 3'd4, 64'hFFFF_FFFF_FFFF_FFFC, 3'd4, 1'b0, 3'd4, 1'b0};
        vt[5]  = '{32'hFFFFE073, 3'd5, 64'h0000_0000_0000_001F, 3'd5, 1'b0, 3'd5, 1'b0};
        vt[6]  = '{32'h00000033, 3'd6, 64'h0,                   3'd7, 1'b1, 3'd6, 1'b1};
        vt[7]  = '{32'h00100073, 3'd0, 64'h1,                   3'd0, 1'b0, 3'd0, 1'b0};
        vt[8]  = '{32'h80002003, 3'd0, 64'hFFFF_FFFF_FFFF_F800, 3'd0, 1'b0, 3'd0, 1'b0};
        vt[9]  = '{32'h7FF0001B, 3'd0, 64'h7FF,                 3'd0, 1'b0, 3'd0, 1'b0};
        vt[10] = '{32'h80000037, 3'd3, 64'hFFFF_FFFF_8000_0000, 3'd3, 1'b0, 3'd3, 1'b0};
        vt[11] = '{32'h7E000FE3, 3'd2, 64'hFFE,                 3'd2, 1'b0, 3'd2, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1;
            inst     = vt[i].inst;
            ext_op   = vt[i].ext;
            tick();
            check($sformatf("vec%0d.a32_valid", i), 64'(if_a32.out_valid), 64'd1);
            check($sformatf("vec%0d.a32_imm", i), 64'(if_a32.imm), {32'b0, vt[i].imm[31:0]});
            check($sformatf("vec%0d.a32_fmt", i), 64'(if_a32.imm_fmt), 64'(vt[i].fmt));
            check($sformatf("vec%0d.a32_no", i), 64'(if_a32.no_imm), 64'(vt[i].no));
            check($sformatf("vec%0d.a64_imm", i), if_a64.imm, vt[i].imm);
            check($sformatf("vec%0d.a64_fmt", i), 64'(if_a64.imm_fmt), 64'(vt[i].fmt));
            check($sformatf("vec%0d.m32_imm", i), 64'(if_m32.imm), {32'b0, vt[i].imm[31:0]});
            check($sformatf("vec%0d.m32_fmt", i), 64'(if_m32.imm_fmt), 64'(vt[i].fmt_m));
            check($sformatf("vec%0d.m32_no", i), 64'(if_m32.no_imm), 64'(vt[i].no_m));
        end
        in_valid = 1'b0;
        tick();
    endtask

    // ---------------- multi-cycle corner sequences ----------------
    task automatic seq_backpressure();
        logic [63:0] got[$];
        bit          acc;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        inst = 32'h00100093; tick();
        check("bp.first_valid", 64'(if_a32.out_valid), 64'd1);
        check("bp.first_ready", 64'(if_a32.in_ready), 64'd1);
        inst = 32'h00200093; tick();
        check("bp.skid_full_ready", 64'(if_a32.in_ready), 64'd0);
        inst = 32'h00300093; tick();
        check("bp.stall_ready", 64'(if_a32.in_ready), 64'd0);
        tick();
        check("bp.stall_ready2", 64'(if_a32.in_ready), 64'd0);
        check("bp.hold_imm", 64'(if_a32.imm), 64'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 10 && (got.size() < 3 || in_valid); k++) begin
            acc = in_valid && if_a32.in_ready;
            if (if_a32.out_valid) got.push_back(64'(if_a32.imm));
            tick();
            if (acc) in_valid = 1'b0;
        end
        check("bp.out_count", 64'(got.size()), 64'd3);
        for (int k = 0; k < got.size() && k < 3; k++)
            check($sformatf("bp.order%0d", k), got[k], 64'(k + 1));
        in_valid = 1'b0;
        check("bp.drained", 64'(if_a32.out_valid), 64'd0);
        tick();
    endtask

    task automatic seq_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        inst = 32'h00500093; tick();
        inst = 32'h00600093; tick();
        check("fl.full", 64'(if_a32.in_ready), 64'd0);
        inst  = 32'h00700093;
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl.out_valid", 64'(if_a32.out_valid), 64'd0);
        check("fl.in_ready", 64'(if_a32.in_ready), 64'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("fl.no_stale%0d", k), 64'(if_a64.out_valid), 64'd0);
        end
        // Input presented in a flush cycle with room available is dropped.
        in_valid = 1'b1;
        inst     = 32'h00800093;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl.drop_input", 64'(if_a32.out_valid), 64'd0);
        tick();
    endtask

    task automatic seq_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        inst = 32'h00700093; tick();
        inst = 32'h00800093; tick();
        rst  = 1'b1;
        inst = 32'hFFF00093; tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        check("rst.out_valid", 64'(if_a32.out_valid), 64'd0);
        check("rst.in_ready", 64'(if_a32.in_ready), 64'd1);
        check("rst.imm", 64'(if_a32.imm), 64'd0);
        check("rst.fmt", 64'(if_a32.imm_fmt), 64'd0);
        check("rst.no_imm", 64'(if_a64.no_imm), 64'd0);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        inst      = 32'h00900093;
        tick();
        in_valid = 1'b0;
        check("rst.first_valid", 64'(if_a32.out_valid), 64'd1);
        check("rst.first_imm32", 64'(if_a32.imm), 64'd9);
        check("rst.first_imm64", if_a64.imm, 64'd9);
        tick();
    endtask

    task automatic run_random(input int cycles);
        logic [6:0] ops[11];
        ops = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b0011011, 7'b0100011, 7'b1100011,
                7'b0110111, 7'b0010111, 7'b1101111, 7'b1110011, 7'b0110011};
        for (int c = 0; c < cycles; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            rst       = ($urandom_range(0, 63) == 0);
            inst      = $urandom;
            if ($urandom_range(0, 7) != 0) inst[6:0] = ops[$urandom_range(0, 10)];
            ext_op = 3'($urandom_range(0, 7));
            tick();
        end
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        inst      = '0;
        ext_op    = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        q.delete();
        after_reset = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        run_table();
        seq_backpressure();
        seq_flush();
        seq_reset();
        run_random(600);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
